mem_responder: RTL

Memory-side responder for the multi-cycle core: services the instruction fetch port (driven by the control unit's instruction-address enable) and the data port (driven by `dbus_re`/`dbus_we`), owns a single-port word memory, and produces the `stall` signal consumed by the control unit. It inserts a configurable number of wait states, arbitrates simultaneous fetch and data requests, and keeps a one-entry last-response buffer per port. Requests that the core holds across several cycles are therefore answered once, not re-executed.

---
 rtl/mem_responder_pkg.sv | 34 +++
 rtl/mem_responder_ram.sv | 31 +++
 rtl/mem_responder.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types for the memory responder: FSM states, request kinds and the
// per-port last-response hold entries.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mem_resp_state_t;

    typedef enum logic [1:0] {
        FETCH,
        DREAD,
        DWRITE
    } mem_req_kind_t;

    typedef struct packed {
        logic        valid;
        logic [29:0] word;
    } ihold_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [29:0] word;
        logic [3:0]  be;
        logic [31:0] wdata;
    } dhold_t;

    function automatic logic word_in_range(input logic [29:0] word, input int depth);
        return {2'b00, word} < 32'(depth);
    endfunction

endpackage

// File: rtl/mem_responder_ram.sv
// Single-port word RAM: synchronous read, byte-lane synchronous write.
module word_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) begin
                        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: wait-state FSM, fetch/data arbitration and per-port
// last-response hold entries in front of a single-port word RAM.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ibus_re,
    input  logic [31:0] iaddr,
    output logic [31:0] idata,
    input  logic        dbus_re,
    input  logic        dbus_we,
    input  logic [31:0] daddr,
    input  logic [31:0] dbus_wdata,
    input  logic [3:0]  dbus_be,
    output logic [31:0] dbus_rdata,
    output logic        stall,
    output logic        fault
);

    localparam int AW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int WCNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LOAD = WCNT_W'(WAIT_STATES);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(1);

    mem_resp_state_t   state_q, state_d;
    mem_req_kind_t     kind_q, sel_kind, cur_kind;
    logic [29:0]       word_q, sel_word, cur_word, i_word, d_word;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic              flt_q, sel_flt, cur_flt;
    logic [WCNT_W-1:0] wcnt_q;
    ihold_t            ihold_q;
    dhold_t            dhold_q;
    logic [31:0]       idata_q, drdata_q, ram_rdata, rd_result;
    logic              d_req, i_hit, d_hit, i_pend, d_pend, accept, access;
    logic              ram_en, ram_we;
    logic              unused_daddr_lsb;

    assign unused_daddr_lsb = ^daddr[1:0];

    // Hit detection and arbitration (data port wins)
    always_comb begin
        i_word = iaddr[31:2];
        d_word = daddr[31:2];
        d_req  = dbus_re | dbus_we;
        i_hit  = ihold_q.valid && (ihold_q.word == i_word);
        if (dbus_we) begin
            d_hit = dhold_q.valid && (dhold_q.word == d_word) && dhold_q.is_write &&
                    (dhold_q.be == dbus_be) && (dhold_q.wdata == dbus_wdata);
        end else begin
            d_hit = dhold_q.valid && (dhold_q.word == d_word) && !dhold_q.is_write;
        end
        i_pend = ibus_re && !i_hit;
        d_pend = d_req && !d_hit;
        if (d_pend) begin
            sel_kind = dbus_we ? DWRITE : DREAD;
            sel_word = d_word;
        end else begin
            sel_kind = FETCH;
            sel_word = i_word;
        end
        sel_flt = !word_in_range(sel_word, DEPTH_WORDS) || (!d_pend && iaddr[1:0] != 2'b00);
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        access  = 1'b0;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                stall = i_pend | d_pend;
                if (i_pend || d_pend) begin
                    accept = 1'b1;
                    if (WAIT_STATES == 0) begin
                        access  = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                stall = i_pend | d_pend;
                if (wcnt_q == WCNT_LAST) begin
                    access  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                // The served port's hold entry only updates at the end of DONE.
                stall   = (kind_q == FETCH) ? d_pend : i_pend;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        if (state_q == IDLE) begin
            cur_kind = sel_kind;
            cur_word = sel_word;
            cur_flt  = sel_flt;
        end else begin
            cur_kind = kind_q;
            cur_word = word_q;
            cur_flt  = flt_q;
        end
        // Gating with rst drops a write that collides with reset.
        ram_we    = (state_q == DONE) && (kind_q == DWRITE) && !flt_q && rst;
        ram_en    = (access && !cur_flt && cur_kind != DWRITE) || ram_we;
        rd_result = flt_q ? 32'h0 : ram_rdata;
        idata      = (state_q == DONE && kind_q == FETCH) ? rd_result : idata_q;
        dbus_rdata = (state_q == DONE && kind_q == DREAD) ? rd_result : drdata_q;
        fault      = (state_q == DONE) && flt_q;
    end

    word_ram #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (cur_word[AW-1:0]),
        .be    (be_q),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            word_q  <= sel_word;
            be_q    <= dbus_be;
            wdata_q <= dbus_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            kind_q   <= FETCH;
            flt_q    <= 1'b0;
            wcnt_q   <= '0;
            ihold_q  <= '0;
            dhold_q  <= '0;
            idata_q  <= '0;
            drdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                kind_q <= sel_kind;
                flt_q  <= sel_flt;
                wcnt_q <= WCNT_LOAD;
            end else if (state_q == BUSY) begin
                wcnt_q <= wcnt_q - WCNT_LAST;
            end
            if (state_q == DONE) begin
                case (kind_q)
                    FETCH: begin
                        idata_q <= rd_result;
                        ihold_q <= '{valid: 1'b1, word: word_q};
                    end
                    DREAD: begin
                        drdata_q <= rd_result;
                        dhold_q  <= '{valid: 1'b1, is_write: 1'b0, word: word_q,
                                      be: be_q, wdata: wdata_q};
                    end
                    DWRITE: begin
                        dhold_q <= '{valid: 1'b1, is_write: 1'b1, word: word_q,
                                     be: be_q, wdata: wdata_q};
                        if (ihold_q.valid && ihold_q.word == word_q) begin
                            ihold_q.valid <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
